// File: rtl/int_to_double.sv
// Converts a signed 64-bit integer to an IEEE-754 binary64 value, round-to-nearest-even.
// Define INT_TO_DOUBLE_FAST_NORM_EN for single-cycle leading-zero normalisation.
module int_to_double (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        get_a     = 3'd0,
        convert_0 = 3'd1,
        normalise = 3'd2,
        round     = 3'd3,
        pack      = 3'd4,
        put_z     = 3'd5
    } state_t;

    state_t      state, state_n;
    logic        ack_n, stb_n;
    logic [63:0] a, a_n;
    logic        sign, sign_n;
    logic        zero, zero_n;
    logic [63:0] mag, mag_n;
    logic [10:0] exp, exp_n;
    logic [51:0] frac, frac_n;
    logic [63:0] z, z_n;
    logic [63:0] out_n;

    // Rounding terms taken from the normalised magnitude; mag[63] is the hidden one.
    logic guard, rnd, sticky, round_up, carry;
    assign guard    = mag[10];
    assign rnd      = mag[9];
    assign sticky   = |mag[8:0];
    assign round_up = guard & (rnd | sticky | mag[11]);
    assign carry    = &mag[63:11];

`ifdef INT_TO_DOUBLE_FAST_NORM_EN
    function automatic logic [6:0] lzc64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd64;
        for (int i = 0; i < 64; i++)
            if (v[i]) n = 7'(63 - i);
        return n;
    endfunction

    logic [6:0] lz;
    assign lz = lzc64(mag);
`endif

    always_comb begin
        state_n = state;
        ack_n   = input_a_ack;
        stb_n   = output_z_stb;
        a_n     = a;
        sign_n  = sign;
        zero_n  = zero;
        mag_n   = mag;
        exp_n   = exp;
        frac_n  = frac;
        z_n     = z;
        out_n   = output_z;
        case (state)
            get_a: begin
                ack_n = 1'b1;
                if (input_a_ack && input_a_stb) begin
                    a_n     = input_a;
                    ack_n   = 1'b0;
                    state_n = convert_0;
                end
            end
            convert_0: begin
                sign_n  = a[63];
                mag_n   = a[63] ? (~a + 64'd1) : a;
                exp_n   = 11'd1086;
                zero_n  = (a == 64'd0);
                state_n = (a == 64'd0) ? pack : normalise;
            end
            normalise: begin
`ifdef INT_TO_DOUBLE_FAST_NORM_EN
                mag_n   = mag << lz;
                exp_n   = exp - 11'(lz);
                state_n = round;
`else
                if (mag[63]) begin
                    state_n = round;
                end else begin
                    mag_n = mag << 1;
                    exp_n = exp - 11'd1;
                end
`endif
            end
            round: begin
                frac_n = mag[62:11];
                if (round_up) begin
                    // All-ones significand rolls over into the next binade.
                    if (carry) begin
                        frac_n = 52'd0;
                        exp_n  = exp + 11'd1;
                    end else begin
                        frac_n = mag[62:11] + 52'd1;
                    end
                end
                state_n = pack;
            end
            pack: begin
                z_n     = zero ? 64'd0 : {sign, exp, frac};
                state_n = put_z;
            end
            put_z: begin
                out_n = z;
                if (output_z_stb && output_z_ack) begin
                    stb_n   = 1'b0;
                    state_n = get_a;
                end else begin
                    stb_n = 1'b1;
                end
            end
            default: begin
                state_n = get_a;
                ack_n   = 1'b0;
                stb_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= get_a;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            state        <= state_n;
            input_a_ack  <= ack_n;
            output_z_stb <= stb_n;
        end
    end

    always_ff @(posedge clk) begin
        a        <= a_n;
        sign     <= sign_n;
        zero     <= zero_n;
        mag      <= mag_n;
        exp      <= exp_n;
        frac     <= frac_n;
        z        <= z_n;
        output_z <= out_n;
    end

endmodule

// File: tb/tb_int_to_double.sv
// Directed self-checking bench for int_to_double: conversions, latency, handshakes, reset abort.
module tb_int_to_double;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int checks = 0;
    int errors = 0;

    int_to_double dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input bit is_zero, input int lz);
        if (is_zero) return 3;
`ifdef INT_TO_DOUBLE_FAST_NORM_EN
        return 5;
`else
        return 5 + lz;
`endif
    endfunction

    // lz is the hand-computed leading-zero count of |val|; busy keeps input_a_stb high during the conversion.
    task automatic conv(input string tag, input logic [63:0] val, input logic [63:0] exp_z,
                        input int lz, input int hold, input bit busy);
        int n;
        n = 0;
        while (input_a_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, 64'(input_a_ack), 64'd1);
        input_a     = val;
        input_a_stb = 1'b1;
        @(negedge clk);
        if (busy) input_a = ~val;
        else input_a_stb = 1'b0;
        n = 0;
        while (output_z_stb !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " no ack while busy"}, 64'(input_a_ack), 64'd0);
        input_a_stb = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat(val == 64'd0, lz)));
        chk({tag, " z"}, output_z, exp_z);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold stb"}, 64'(output_z_stb), 64'd1);
            chk({tag, " hold z"}, output_z, exp_z);
        end
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk({tag, " stb fall"}, 64'(output_z_stb), 64'd0);
        chk({tag, " ack low"}, 64'(input_a_ack), 64'd0);
        @(negedge clk);
        chk({tag, " ack rise"}, 64'(input_a_ack), 64'd1);
    endtask

    initial begin
        int stray;
        rst          = 1'b1;
        input_a      = 64'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ack", 64'(input_a_ack), 64'd0);
        chk("reset stb", 64'(output_z_stb), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset ack", 64'(input_a_ack), 64'd1);

        conv("one",      64'h0000000000000001, 64'h3FF0000000000000, 63, 0, 1'b0);
        conv("minus1",   64'hFFFFFFFFFFFFFFFF, 64'hBFF0000000000000, 63, 0, 1'b0);
        conv("zero",     64'h0000000000000000, 64'h0000000000000000, 0,  0, 1'b0);
        conv("tie_even", 64'h0020000000000001, 64'h4340000000000000, 10, 0, 1'b0);
        conv("tie_up",   64'h0020000000000003, 64'h4340000000000002, 10, 0, 1'b0);
        conv("neg_tie",  64'hFFDFFFFFFFFFFFFD, 64'hC340000000000002, 10, 0, 1'b0);
        conv("min_int",  64'h8000000000000000, 64'hC3E0000000000000, 0,  0, 1'b0);
        conv("max_int",  64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000, 1,  0, 1'b0);
        conv("k1000",    64'd1000,             64'h408F400000000000, 54, 10, 1'b0);
        conv("neg1000",  64'hFFFFFFFFFFFFFC18, 64'hC08F400000000000, 54, 0, 1'b1);

        // Abort a conversion of 1 while it sits in normalise.
        input_a     = 64'h0000000000000001;
        input_a_stb = 1'b1;
        @(negedge clk);
        input_a_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort stb", 64'(output_z_stb), 64'd0);
        chk("abort ack", 64'(input_a_ack), 64'd0);
        @(negedge clk);
        chk("abort ack rise", 64'(input_a_ack), 64'd1);
        stray = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (output_z_stb !== 1'b0) stray++;
        end
        chk("abort no pulse", 64'(stray), 64'd0);
        conv("after_abort", 64'h0000000000000002, 64'h4000000000000000, 62, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_to_double.md
INT_TO_DOUBLE -- requirements
Module: int_to_double

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input_a  input  64  signed two's-complement integer operand.
REQ-005 input_a_stb  input  1  producer asserts while input_a is valid.
REQ-006 input_a_ack  output  1  block ready to accept; registered.
REQ-007 output_z  output  64  IEEE-754 binary64 result; registered.
REQ-008 output_z_stb  output  1  output_z valid; registered.
REQ-009 output_z_ack  input  1  consumer (e.g. double_adder operand port) accepts output_z.

Function
REQ-010 The FSM SHALL use the states get_a, convert_0, normalise, round, pack and put_z, encoded in a 3-bit state register.
REQ-011 In get_a, input_a_ack SHALL be set to 1 on the next edge; the transfer occurs on an edge where input_a_ack=1 and input_a_stb=1: latch input_a, clear input_a_ack, go to convert_0.
REQ-012 In convert_0 the block SHALL register sign = a[63], magnitude = |a| as 64-bit unsigned (-2^63 yields 0x8000000000000000), exponent = 1086 (1023+63); zero input goes directly to pack with a zero flag set.
REQ-013 In normalise, while magnitude[63]=0 the block SHALL shift magnitude left by one and decrement exponent; on magnitude[63]=1 go to round.
REQ-014 Round SHALL be round-to-nearest-even: mantissa = magnitude[63:11], guard = bit 10, round = bit 9, sticky = OR of bits 8:0; increment mantissa when guard & (round | sticky | mantissa[0]).
REQ-015 If the mantissa is all ones (53'h1FFFFFFFFFFFFF) when incremented, the block SHALL set the mantissa to 53'h10000000000000 and increment the exponent.
REQ-016 In pack the block SHALL form z = {sign, exponent[10:0], mantissa[51:0]}; a zero input SHALL produce 64'h0000000000000000 (sign 0). Overflow, NaN and denormal outputs are impossible and SHALL NOT be generated.
REQ-017 In put_z the block SHALL set output_z_stb=1 and output_z=z; on an edge with output_z_stb=1 and output_z_ack=1 it SHALL clear output_z_stb and return to get_a.
REQ-018 output_z SHALL hold stable while output_z_stb=1; input_a_ack SHALL be 0 in every state other than get_a.
REQ-019 input_a_stb asserted outside get_a SHALL be ignored without data loss for the producer (no ack issued).
REQ-020 Latency from the accept edge to the first edge with output_z_stb=1 SHALL be 5 cycles with REQ-024 enabled; 5 + (leading-zero count of magnitude) cycles without it; zero input always 3 cycles.

Reset
REQ-021 On an edge with rst=1 the block SHALL enter get_a and clear input_a_ack and output_z_stb, overriding any same-cycle transition.
REQ-022 Reset mid-conversion SHALL discard the operation in progress; no output_z_stb pulse for it SHALL follow.
REQ-023 output_z and internal datapath registers need not be reset; their values are don't-care while output_z_stb=0.

Configuration
REQ-024 Macro INT_TO_DOUBLE_FAST_NORM_EN: when defined, normalise SHALL complete in exactly one cycle using a 64-bit leading-zero count (shift left by lzc, exponent -= lzc); when undefined, normalise SHALL shift one bit per cycle per REQ-013. Results SHALL be bit-identical in both builds.

Verification
REQ-025 input_a=0x0000000000000001 -> output_z=0x3FF0000000000000; input_a=0xFFFFFFFFFFFFFFFF (-1) -> 0xBFF0000000000000.
REQ-026 input_a=0 -> output_z=0x0000000000000000, 3 cycles after accept.
REQ-027 Rounding: 0x0020000000000001 (2^53+1) -> 0x4340000000000000 (tie, even); 0x0020000000000003 -> 0x4340000000000002 (tie, up).
REQ-028 Extremes: 0x8000000000000000 -> 0xC3E0000000000000; 0x7FFFFFFFFFFFFFFF -> 0x43E0000000000000 (mantissa carry-out, exponent +1).
REQ-029 Hold output_z_ack=0 for 10 cycles in put_z -> output_z_stb stays 1 and output_z stable; assert ack -> stb falls next edge, input_a_ack rises the edge after.
REQ-030 Assert rst for one cycle while in normalise with input 0x0000000000000001 -> next cycle state get_a, output_z_stb=0; subsequent input 0x0000000000000002 -> 0x4000000000000000.
